weight_drm_rd_ctrl: RTL and testbench

// Read-side sequencer for the weight DRM bank. Issues read addresses to the bank, absorbs its

---
 rtl/weight_drm_rd_ctrl.sv | 105 ++++++++++
 tb/tb_weight_drm_rd_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/weight_drm_rd_ctrl.sv
// weight_drm_rd_ctrl: replays a weight bank address range over N passes and streams the words through a credit-limited FIFO
module weight_drm_rd_ctrl #(
  parameter int DATA_WIDTH    = 1296,
  parameter int RD_ADDR_DEPTH = 8,
  parameter int RD_LATENCY    = 1,
  parameter int PASS_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [RD_ADDR_DEPTH-1:0] cfg_base_addr,
  input  logic [RD_ADDR_DEPTH:0]   cfg_len,
  input  logic [PASS_WIDTH-1:0]    cfg_passes,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic [RD_ADDR_DEPTH-1:0] WeightDRM_addr_rd,
  input  logic [DATA_WIDTH-1:0]    WeightDRM_data_rd,
  output logic [DATA_WIDTH-1:0]    weight_data,
  output logic                     weight_valid,
  input  logic                     weight_ready,
  output logic                     weight_last
);
  localparam int FIFO_DEPTH = RD_LATENCY + 2;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [RD_ADDR_DEPTH-1:0] base;
  logic [RD_ADDR_DEPTH:0] len, idx;
  logic [PASS_WIDTH-1:0] passes, pass_cnt;
  logic [RD_LATENCY:0] tag_v, tag_l;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_l;
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic accept, zero_cfg, push, pop, issue, word_last, run_last, drained, done_nx;
  int credits;
  assign busy = state != IDLE;
  assign weight_valid = cnt != '0;
  assign weight_data = weight_valid ? mem[rp] : '0;
  assign weight_last = weight_valid && mem_l[rp];
  always_comb begin
    accept = start && state == IDLE && !abort;
    zero_cfg = cfg_len == '0 || cfg_passes == '0;
    pop = weight_valid && weight_ready;
    push = tag_v[RD_LATENCY];
    credits = int'(cnt) + $countones(tag_v) - int'(pop);
    issue = state == RUN && !abort && credits < FIFO_DEPTH;
    word_last = idx == len - 1'b1;
    run_last = word_last && pass_cnt == passes - 1'b1;
    drained = tag_v == '0 && (cnt == '0 || (cnt == CW'(1) && pop));
    state_nx = state;
    done_nx = 1'b0;
    if (abort) state_nx = IDLE;
    else if (accept) begin
      state_nx = zero_cfg ? IDLE : RUN;
      done_nx = zero_cfg;
    end else if (issue && run_last) state_nx = DRAIN;
    else if (state == DRAIN && drained) begin
      state_nx = IDLE;
      done_nx = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_nx;
    done <= !rst && done_nx;
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      base <= cfg_base_addr;
      len <= cfg_len;
      passes <= cfg_passes;
      idx <= '0;
      pass_cnt <= '0;
    end else if (issue) begin
      idx <= word_last ? '0 : idx + 1'b1;
      pass_cnt <= pass_cnt + PASS_WIDTH'(word_last);
    end
    if (rst) WeightDRM_addr_rd <= '0;
    else if (issue) WeightDRM_addr_rd <= base + idx[RD_ADDR_DEPTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      tag_v <= '0;
      tag_l <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      tag_v <= {tag_v[RD_LATENCY-1:0], issue};
      tag_l <= {tag_l[RD_LATENCY-1:0], issue && word_last};
      if (push) wp <= wp == PW'(FIFO_DEPTH - 1) ? '0 : wp + 1'b1;
      if (pop) rp <= rp == PW'(FIFO_DEPTH - 1) ? '0 : rp + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= WeightDRM_data_rd;
      mem_l[wp] <= tag_l[RD_LATENCY];
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !pop && cnt == CW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_weight_drm_rd_ctrl.sv
// tb_weight_drm_rd_ctrl: directed table plus corner sequences against a latency-accurate bank model
module tb_weight_drm_rd_ctrl;
  localparam int L = 1;
  logic clk = 0, rst = 1, start = 0, abort = 0, weight_ready = 1;
  logic [7:0] cfg_base_addr = 0, addr_rd;
  logic [8:0] cfg_len = 0;
  logic [7:0] cfg_passes = 0;
  logic busy, done, weight_valid, weight_last;
  logic [1295:0] data_rd, weight_data;
  logic [7:0] bank_pipe [L];
  int cyc = 0, checks = 0, failures = 0;
  int first_v, done_cnt, done_cyc, bad_data;
  int q_a[$], q_c[$];
  bit q_l[$];
  typedef struct {
    logic [7:0] base;
    logic [8:0] len;
    logic [7:0] passes;
    bit rnd;
    bit spur;
    int n;
    int first;
    int fin;
    int lasts;
  } vec_t;
  vec_t vecs[7];
  vec_t clean_v;
  weight_drm_rd_ctrl #(.DATA_WIDTH(1296), .RD_ADDR_DEPTH(8), .RD_LATENCY(L), .PASS_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_base_addr(cfg_base_addr), .cfg_len(cfg_len),
    .cfg_passes(cfg_passes), .abort(abort), .busy(busy), .done(done), .WeightDRM_addr_rd(addr_rd),
    .WeightDRM_data_rd(data_rd), .weight_data(weight_data), .weight_valid(weight_valid),
    .weight_ready(weight_ready), .weight_last(weight_last)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bank_pipe[0] <= addr_rd;
    for (int i = 1; i < L; i++) bank_pipe[i] <= bank_pipe[i-1];
  end
  assign data_rd = {162{bank_pipe[L-1]}};
  always @(negedge clk) begin
    if (weight_valid && first_v < 0) first_v = cyc;
    if (weight_valid && weight_ready) begin
      q_a.push_back(int'(weight_data[7:0]));
      q_l.push_back(weight_last);
      q_c.push_back(cyc);
      if (weight_data != {162{weight_data[7:0]}}) bad_data++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  task automatic clear_mon();
    q_a.delete();
    q_l.delete();
    q_c.delete();
    first_v = -1;
    done_cnt = 0;
    done_cyc = -1;
    bad_data = 0;
  endtask
  task automatic kick(input logic [7:0] b, input logic [8:0] n, input logic [7:0] p);
    @(posedge clk); #1;
    cfg_base_addr = b;
    cfg_len = n;
    cfg_passes = p;
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask
  task automatic run(input vec_t v, input string tag);
    int t0, bud, seq_err, lasts, k;
    clear_mon();
    @(posedge clk); #1;
    cfg_base_addr = v.base;
    cfg_len = v.len;
    cfg_passes = v.passes;
    start = 1;
    t0 = cyc + 1;
    @(posedge clk); #1;
    start = 0;
    bud = 0;
    while (done_cnt == 0 && bud < 3000) begin
      weight_ready = v.rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      start = v.spur && bud == 2;
      cfg_base_addr = v.spur ? 8'd200 : v.base;
      cfg_len = v.spur ? 9'd2 : v.len;
      @(posedge clk); #1;
      bud++;
    end
    start = 0;
    weight_ready = 1;
    repeat (5) @(posedge clk);
    #1;
    seq_err = bad_data;
    lasts = 0;
    for (int i = 0; i < q_a.size(); i++) begin
      k = i % int'(v.len);
      if (q_a[i] != ((int'(v.base) + k) % 256) || q_l[i] != (k == int'(v.len) - 1)) seq_err++;
      if (q_l[i]) lasts++;
    end
    check({tag, ".count"}, q_a.size(), v.n);
    check({tag, ".first"}, q_a.size() > 0 ? q_a[0] : -1, v.first);
    check({tag, ".final"}, q_a.size() > 0 ? q_a[q_a.size()-1] : -1, v.fin);
    check({tag, ".lasts"}, lasts, v.lasts);
    check({tag, ".seq"}, seq_err, 0);
    check({tag, ".latency"}, first_v - t0, 2 + L);
    check({tag, ".done_cnt"}, done_cnt, 1);
    check({tag, ".done_after_last"}, q_c.size() > 0 ? done_cyc - q_c[q_c.size()-1] : -1, 1);
    if (!v.rnd) check({tag, ".no_gap"}, q_c.size() > 0 ? q_c[q_c.size()-1] - q_c[0] : -1, v.n - 1);
    check({tag, ".idle_busy"}, busy, 0);
  endtask
  task automatic interrupt(input bit use_rst, input string tag);
    int bud;
    clear_mon();
    kick(8'd0, 9'd8, 8'd1);
    bud = 0;
    while (q_a.size() < 2 && bud < 100) begin
      @(posedge clk); #1;
      bud++;
    end
    if (use_rst) rst = 1;
    else abort = 1;
    @(posedge clk); #1;
    rst = 0;
    abort = 0;
    check({tag, ".valid"}, weight_valid, 0);
    check({tag, ".busy"}, busy, 0);
    if (use_rst) check({tag, ".addr"}, addr_rd, 0);
    repeat (10) @(posedge clk);
    #1;
    check({tag, ".done_cnt"}, done_cnt, 0);
    check({tag, ".words"}, q_a.size(), 3);
    run(clean_v, {tag, ".restart"});
  endtask
  initial begin
    vecs[0] = '{8'd0, 9'd4, 8'd1, 1'b0, 1'b0, 4, 0, 3, 1};
    vecs[1] = '{8'd254, 9'd4, 8'd1, 1'b0, 1'b0, 4, 254, 1, 1};
    vecs[2] = '{8'd5, 9'd2, 8'd3, 1'b0, 1'b0, 6, 5, 6, 3};
    vecs[3] = '{8'd100, 9'd16, 8'd1, 1'b1, 1'b0, 16, 100, 115, 1};
    vecs[4] = '{8'd250, 9'd256, 8'd1, 1'b0, 1'b0, 256, 250, 249, 1};
    vecs[5] = '{8'd10, 9'd3, 8'd2, 1'b1, 1'b0, 6, 10, 12, 2};
    vecs[6] = '{8'd30, 9'd6, 8'd1, 1'b0, 1'b1, 6, 30, 35, 1};
    clean_v = '{8'd20, 9'd3, 8'd1, 1'b0, 1'b0, 3, 20, 22, 1};
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.valid", weight_valid, 0);
    check("reset.last", weight_last, 0);
    check("reset.addr", addr_rd, 0);
    check("reset.data_zero", weight_data == '0, 1);
    for (int i = 0; i < 7; i++) run(vecs[i], $sformatf("vec%0d", i));
    interrupt(1'b0, "abort");
    interrupt(1'b1, "rst");
    begin
      logic [7:0] a0;
      a0 = addr_rd;
      kick(8'd77, 9'd0, 8'd3);
      check("len0.done", done, 1);
      check("len0.busy", busy, 0);
      @(posedge clk); #1;
      check("len0.done_one_cycle", done, 0);
      check("len0.addr", addr_rd, a0);
      kick(8'd77, 9'd4, 8'd0);
      check("pass0.done", done, 1);
      check("pass0.busy", busy, 0);
      @(posedge clk); #1;
      check("pass0.addr", addr_rd, a0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
